// File: rtl/serial_tl_pkg.sv
// rtl/serial_tl_pkg.sv - shared parameters and types for the serial TL host bridge
package serial_tl_pkg;

    localparam int DEFAULT_WORD_W   = 32;
    localparam int DEFAULT_RX_DEPTH = 2;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // Both link directions move bit 0 of a word first; the chip-side model relies on this.
    localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_tl_rx_fifo.sv
// rtl/serial_tl_rx_fifo.sv - synchronous word FIFO holding reassembled RX words
module serial_tl_rx_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    // Stale storage is masked so the head reads as zero whenever nothing is queued.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/serial_tl_host_bridge.sv
// rtl/serial_tl_host_bridge.sv - host endpoint of the 1-bit serial TileLink link
module serial_tl_host_bridge
    import serial_tl_pkg::*;
#(
    parameter int WORD_W   = DEFAULT_WORD_W,
    parameter int RX_DEPTH = DEFAULT_RX_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [WORD_W-1:0] tx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [WORD_W-1:0] rx_data,
    output logic              serial_tl_bits_in_valid,
    output logic              serial_tl_bits_in_bits,
    input  logic              serial_tl_bits_in_ready,
    input  logic              serial_tl_bits_out_valid,
    input  logic              serial_tl_bits_out_bits,
    output logic              serial_tl_bits_out_ready
);

    localparam int                   BIT_CNT_W = $clog2(WORD_W);
    localparam int                   CNT_W     = $clog2(RX_DEPTH) + 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WORD_W - 1);

    tx_state_t             tx_state;
    logic [WORD_W-1:0]     tx_shift;
    logic [BIT_CNT_W-1:0]  tx_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_cnt   <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        tx_shift <= tx_data;
                        tx_cnt   <= '0;
                        tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (serial_tl_bits_in_ready) begin
                        tx_shift <= {1'b0, tx_shift[WORD_W-1:1]};
                        tx_cnt   <= tx_cnt + BIT_CNT_W'(1);
                        if (tx_cnt == LAST_BIT) begin
                            tx_state <= TX_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_ready                = (tx_state == TX_IDLE);
    assign serial_tl_bits_in_valid = (tx_state == TX_SHIFT);
    assign serial_tl_bits_in_bits  = tx_shift[0];

    // Only the WORD_W-1 earlier bits are stored; the final bit joins straight from the wire.
    logic [WORD_W-2:0]    rx_shift;
    logic [BIT_CNT_W-1:0] rx_cnt;
    logic [WORD_W-1:0]    rx_word;
    logic                 rx_accept;
    logic                 rx_push;
    logic                 rx_pop;
    logic [CNT_W-1:0]     rx_count;
    logic                 rx_full;
    logic                 rx_empty;
    logic                 rx_full_unused;

    assign serial_tl_bits_out_ready = (rx_count != CNT_W'(RX_DEPTH));
    assign rx_accept = serial_tl_bits_out_valid & serial_tl_bits_out_ready;
    assign rx_word   = {serial_tl_bits_out_bits, rx_shift};
    assign rx_push   = rx_accept & (rx_cnt == LAST_BIT);
    assign rx_valid  = ~rx_empty;
    assign rx_pop    = rx_valid & rx_ready;
    assign rx_full_unused = rx_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_shift <= '0;
            rx_cnt   <= '0;
        end else if (rx_accept) begin
            rx_shift <= rx_word[WORD_W-1:1];
            rx_cnt   <= rx_push ? '0 : rx_cnt + BIT_CNT_W'(1);
        end
    end

    serial_tl_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_word),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule

// File: tb/tb_serial_tl_host_bridge.sv
// tb/tb_serial_tl_host_bridge.sv - scoreboard bench for the serial TL host bridge
module tb_serial_tl_host_bridge;

    localparam int W        = 32;
    localparam int DEPTH    = 2;
    localparam int M_ALWAYS = 0;
    localparam int M_PATTERN = 1;
    localparam int M_RANDOM = 2;
    localparam int M_NEVER  = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] tx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] rx_data;
    logic         serial_tl_bits_in_valid;
    logic         serial_tl_bits_in_bits;
    logic         serial_tl_bits_in_ready;
    logic         serial_tl_bits_out_valid;
    logic         serial_tl_bits_out_bits;
    logic         serial_tl_bits_out_ready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tx_mode, in_mode, out_mode, rx_mode;
    int pat_idx = 0;

    logic [W-1:0] tx_pending[$];
    logic [W-1:0] tx_exp[$];
    logic [W-1:0] rx_exp[$];
    logic         rx_bits_q[$];

    logic [W-1:0] tx_asm = '0;
    int tx_bit_cnt = 0;
    int rx_bit_cnt = 0;
    int rx_words_in = 0;
    int rx_words_out = 0;
    int rx_last_edge = 0;
    logic hold_prev_valid = 1'b0;
    logic hold_prev_bit = 1'b0;

    serial_tl_host_bridge #(
        .WORD_W   (W),
        .RX_DEPTH (DEPTH)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .tx_valid                 (tx_valid),
        .tx_ready                 (tx_ready),
        .tx_data                  (tx_data),
        .rx_valid                 (rx_valid),
        .rx_ready                 (rx_ready),
        .rx_data                  (rx_data),
        .serial_tl_bits_in_valid  (serial_tl_bits_in_valid),
        .serial_tl_bits_in_bits   (serial_tl_bits_in_bits),
        .serial_tl_bits_in_ready  (serial_tl_bits_in_ready),
        .serial_tl_bits_out_valid (serial_tl_bits_out_valid),
        .serial_tl_bits_out_bits  (serial_tl_bits_out_bits),
        .serial_tl_bits_out_ready (serial_tl_bits_out_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic pick(input int mode, input int idx);
        case (mode)
            M_ALWAYS:  return 1'b1;
            M_PATTERN: return (idx % 4 == 0) || (idx % 4 == 3);
            M_RANDOM:  return $urandom_range(0, 1) == 1;
            default:   return 1'b0;
        endcase
    endfunction

    task automatic send_tx(input logic [W-1:0] w);
        tx_pending.push_back(w);
        tx_exp.push_back(w);
    endtask

    task automatic send_rx(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) rx_bits_q.push_back(w[i]);
        rx_exp.push_back(w);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, ".tx_ready"}, tx_ready, 1);
        check_eq({pfx, ".bits_in_valid"}, serial_tl_bits_in_valid, 0);
        check_eq({pfx, ".bits_in_bits"}, serial_tl_bits_in_bits, 0);
        check_eq({pfx, ".rx_valid"}, rx_valid, 0);
        check_eq({pfx, ".rx_data"}, rx_data, 0);
        check_eq({pfx, ".bits_out_ready"}, serial_tl_bits_out_ready, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((tx_pending.size() != 0 || tx_exp.size() != 0 || rx_bits_q.size() != 0 ||
                rx_exp.size() != 0) && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq(tag, n < budget, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Both sides of the link plus the host: decide inputs for the next rising edge and score its handshakes.
    always @(negedge clock) begin
        if (reset) begin
            tx_valid = 1'b0;
            tx_data = '0;
            serial_tl_bits_in_ready = 1'b0;
            serial_tl_bits_out_valid = 1'b0;
            serial_tl_bits_out_bits = 1'b0;
            rx_ready = 1'b0;
            tx_pending.delete();
            tx_exp.delete();
            rx_bits_q.delete();
            rx_exp.delete();
            tx_asm = '0;
            tx_bit_cnt = 0;
            rx_bit_cnt = 0;
            hold_prev_valid = 1'b0;
        end else begin
            tx_valid = (tx_pending.size() != 0) && pick(tx_mode, 0);
            tx_data = tx_valid ? tx_pending[0] : '0;
            if (tx_valid && tx_ready) void'(tx_pending.pop_front());

            serial_tl_bits_in_ready = pick(in_mode, pat_idx);
            if (in_mode == M_PATTERN) pat_idx++;
            if (serial_tl_bits_in_valid && hold_prev_valid)
                check_eq("tx_bit_hold", serial_tl_bits_in_bits, hold_prev_bit);
            hold_prev_valid = serial_tl_bits_in_valid && !serial_tl_bits_in_ready;
            hold_prev_bit = serial_tl_bits_in_bits;
            if (serial_tl_bits_in_valid && serial_tl_bits_in_ready) begin
                tx_asm = {serial_tl_bits_in_bits, tx_asm[W-1:1]};
                tx_bit_cnt++;
                if (tx_bit_cnt == W) begin
                    tx_bit_cnt = 0;
                    check_eq("tx_word_expected", tx_exp.size() != 0, 1);
                    if (tx_exp.size() != 0) check_eq("tx_word", tx_asm, tx_exp.pop_front());
                end
            end

            serial_tl_bits_out_valid = (rx_bits_q.size() != 0) && pick(out_mode, 0);
            serial_tl_bits_out_bits = serial_tl_bits_out_valid ? rx_bits_q[0] : 1'b0;
            if (serial_tl_bits_out_valid && serial_tl_bits_out_ready) begin
                void'(rx_bits_q.pop_front());
                rx_bit_cnt++;
                if (rx_bit_cnt == W) begin
                    rx_bit_cnt = 0;
                    rx_words_in++;
                    rx_last_edge = cyc + 1;
                end
            end

            rx_ready = pick(rx_mode, 0);
            if (rx_valid && rx_ready) begin
                rx_words_out++;
                check_eq("rx_word_expected", rx_exp.size() != 0, 1);
                if (rx_exp.size() != 0) check_eq("rx_word", rx_data, rx_exp.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, nval, cycn, rdy_at, nrx, rx_at, base, base_out;
        bit started, seen;

        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        rx_ready = 1'b0;
        serial_tl_bits_in_ready = 1'b0;
        serial_tl_bits_out_valid = 1'b0;
        serial_tl_bits_out_bits = 1'b0;
        tx_mode = M_ALWAYS;
        in_mode = M_ALWAYS;
        out_mode = M_ALWAYS;
        rx_mode = M_ALWAYS;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock); #1;
        check_reset_outputs("reset_release");

        send_tx(32'h0000_0005);
        nval = 0; cycn = 0; rdy_at = 0; started = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            if (serial_tl_bits_in_valid) begin
                started = 1;
                nval++;
            end
            if (started) begin
                cycn++;
                if (tx_ready && rdy_at == 0) rdy_at = cycn;
            end
        end
        check_eq("tx_valid_cycles", nval, 32);
        check_eq("tx_ready_return_cycle", rdy_at, 33);
        wait_idle("tx_single_drain", 100);

        in_mode = M_PATTERN;
        pat_idx = 0;
        send_tx(32'hA5A5_A5A5);
        wait_idle("tx_backpressure_drain", 300);
        in_mode = M_ALWAYS;

        send_rx(32'hDEAD_BEEF);
        nrx = 0; rx_at = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock); #1;
            if (rx_valid) begin
                nrx++;
                if (rx_at == 0) rx_at = cyc;
            end
        end
        check_eq("rx_valid_pulses", nrx, 1);
        check_eq("rx_valid_edge", rx_at, rx_last_edge);
        wait_idle("rx_word_drain", 100);

        rx_mode = M_NEVER;
        base = rx_words_in;
        send_rx(32'h1111_0001);
        send_rx(32'h2222_0002);
        send_rx(32'h3333_0003);
        seen = 0; n = 0;
        while (!seen && n < 300) begin
            @(posedge clock); #1;
            n++;
            if (rx_words_in - base == 2) begin
                seen = 1;
                check_eq("rx_full_ready_drop", serial_tl_bits_out_ready, 0);
            end
        end
        check_eq("rx_full_reached", seen, 1);
        repeat (20) @(posedge clock);
        #1;
        check_eq("rx_full_ready_low", serial_tl_bits_out_ready, 0);
        check_eq("rx_word3_waiting", serial_tl_bits_out_valid, 1);
        check_eq("rx_word3_no_bits", rx_bit_cnt, 0);
        check_eq("rx_full_words", rx_words_in - base, 2);
        rx_mode = M_ALWAYS;
        @(posedge clock); #1;
        check_eq("rx_ready_after_pop", serial_tl_bits_out_ready, 1);
        wait_idle("rx_full_drain", 400);

        send_tx(32'hCAFE_F00D);
        send_rx(32'h0BAD_CAFE);
        n = 0;
        while (!(tx_bit_cnt >= 10 && rx_bit_cnt >= 10) && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        check_eq("reset_mid_progress", n < 200, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("reset_mid");
        reset = 1'b0;
        @(posedge clock); #1;
        check_reset_outputs("reset_mid_release");
        send_tx(32'h1234_5678);
        send_rx(32'h8765_4321);
        wait_idle("reset_mid_after", 300);

        tx_mode = M_RANDOM;
        in_mode = M_RANDOM;
        out_mode = M_RANDOM;
        rx_mode = M_RANDOM;
        base_out = rx_words_out;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clock); #1;
            if (tx_pending.size() < 2 && $urandom_range(0, 7) == 0) send_tx($urandom);
            if (rx_bits_q.size() < W && $urandom_range(0, 7) == 0) send_rx($urandom);
        end
        tx_mode = M_ALWAYS;
        in_mode = M_ALWAYS;
        out_mode = M_ALWAYS;
        rx_mode = M_ALWAYS;
        wait_idle("random_drain", 3000);
        check_eq("random_rx_words_seen", (rx_words_out - base_out) > 50, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
